// File: rtl/axi_lite_reg_bridge_if.sv
// rtl/axi_lite_reg_bridge_if.sv - AXI4-Lite slave channels plus register request bus
interface axi_lite_reg_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] aw_addr_i;
    logic                  aw_valid_i;
    logic                  aw_ready_o;
    logic [DATA_WIDTH-1:0] w_data_i;
    logic [STRB_WIDTH-1:0] w_strb_i;
    logic                  w_valid_i;
    logic                  w_ready_o;
    logic [1:0]            b_resp_o;
    logic                  b_valid_o;
    logic                  b_ready_i;
    logic [ADDR_WIDTH-1:0] ar_addr_i;
    logic                  ar_valid_i;
    logic                  ar_ready_o;
    logic [DATA_WIDTH-1:0] r_data_o;
    logic [1:0]            r_resp_o;
    logic                  r_valid_o;
    logic                  r_ready_i;
    logic                  reg_valid_o;
    logic                  reg_ready_i;
    logic                  reg_write_o;
    logic [ADDR_WIDTH-1:0] reg_addr_o;
    logic [DATA_WIDTH-1:0] reg_wdata_o;
    logic [STRB_WIDTH-1:0] reg_wstrb_o;
    logic [DATA_WIDTH-1:0] reg_rdata_i;
    logic                  reg_error_i;

    // Bridge view: AXI slave on one side, register request master on the other
    modport slave (
        input  aw_addr_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i, b_ready_i,
        input  ar_addr_i, ar_valid_i, r_ready_i, reg_ready_i, reg_rdata_i, reg_error_i,
        output aw_ready_o, w_ready_o, b_resp_o, b_valid_o, ar_ready_o,
        output r_data_o, r_resp_o, r_valid_o,
        output reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o
    );

    // Environment view: AXI master plus register file
    modport master (
        output aw_addr_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i, b_ready_i,
        output ar_addr_i, ar_valid_i, r_ready_i, reg_ready_i, reg_rdata_i, reg_error_i,
        input  aw_ready_o, w_ready_o, b_resp_o, b_valid_o, ar_ready_o,
        input  r_data_o, r_resp_o, r_valid_o,
        input  reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o
    );
endinterface

// File: rtl/axi_lite_reg_bridge.sv
// rtl/axi_lite_reg_bridge.sv - AXI4-Lite to single-outstanding register bus bridge
module axi_lite_reg_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    axi_lite_reg_bridge_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WRESP = 2'd2;
    localparam logic [1:0] S_RRESP = 2'd3;

    localparam logic PRIO_WRITE = 1'b0;
    localparam logic PRIO_READ  = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0] state;
    logic       prio;
    logic       wr_elig;
    logic       rd_elig;
    logic       grant_wr;
    logic       grant_rd;

    // Round-robin arbitration between a complete AW+W pair and an AR; only in IDLE
    always_comb begin
        wr_elig  = bus.aw_valid_i & bus.w_valid_i;
        rd_elig  = bus.ar_valid_i;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (!rst_i && state == S_IDLE) begin
            grant_wr = wr_elig & (!rd_elig | (prio == PRIO_WRITE));
            grant_rd = rd_elig & (!wr_elig | (prio == PRIO_READ));
        end
    end

    assign bus.aw_ready_o = grant_wr;
    assign bus.w_ready_o  = grant_wr;
    assign bus.ar_ready_o = grant_rd;

    // Transaction FSM: accept, issue register request, return AXI response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= S_IDLE;
            prio            <= PRIO_WRITE;
            bus.reg_valid_o <= 1'b0;
            bus.reg_write_o <= 1'b0;
            bus.reg_addr_o  <= '0;
            bus.reg_wdata_o <= '0;
            bus.reg_wstrb_o <= '0;
            bus.b_valid_o   <= 1'b0;
            bus.b_resp_o    <= RESP_OKAY;
            bus.r_valid_o   <= 1'b0;
            bus.r_data_o    <= '0;
            bus.r_resp_o    <= RESP_OKAY;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_wr) begin
                        prio            <= PRIO_READ;
                        bus.reg_valid_o <= 1'b1;
                        bus.reg_write_o <= 1'b1;
                        bus.reg_addr_o  <= bus.aw_addr_i;
                        bus.reg_wdata_o <= bus.w_data_i;
                        bus.reg_wstrb_o <= bus.w_strb_i;
                        state           <= S_REQ;
                    end else if (grant_rd) begin
                        prio            <= PRIO_WRITE;
                        bus.reg_valid_o <= 1'b1;
                        bus.reg_write_o <= 1'b0;
                        bus.reg_addr_o  <= bus.ar_addr_i;
                        bus.reg_wdata_o <= '0;
                        bus.reg_wstrb_o <= '0;
                        state           <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Request fields stay frozen until the register side completes
                    if (bus.reg_ready_i) begin
                        bus.reg_valid_o <= 1'b0;
                        if (bus.reg_write_o) begin
                            bus.b_valid_o <= 1'b1;
                            bus.b_resp_o  <= bus.reg_error_i ? RESP_SLVERR : RESP_OKAY;
                            state         <= S_WRESP;
                        end else begin
                            bus.r_valid_o <= 1'b1;
                            bus.r_data_o  <= bus.reg_rdata_i;
                            bus.r_resp_o  <= bus.reg_error_i ? RESP_SLVERR : RESP_OKAY;
                            state         <= S_RRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (bus.b_ready_i) begin
                        bus.b_valid_o <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                S_RRESP: begin
                    if (bus.r_ready_i) begin
                        bus.r_valid_o <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// tb/tb_axi_lite_reg_bridge.sv - self-checking bench for axi_lite_reg_bridge
module tb_axi_lite_reg_bridge;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_reg_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_reg_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Register file seen by the bridge, and the arbiter's expected next winner
    logic [31:0] mem [logic [31:0]];
    bit          exp_prio_w;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One complete transaction whose AXI request is already being driven
    task automatic run_txn(input string tag, input bit is_wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb, input bit err,
                           input int stall, input int rstall);
        logic [31:0] rd;
        logic [31:0] merged;
        logic [1:0]  exp_resp;
        rd       = is_wr ? $urandom : mem_rd(addr);
        exp_resp = err ? 2'b10 : 2'b00;
        #1;
        checks++; if ({bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o} !== {is_wr, is_wr, !is_wr}) begin errors++; $display("FAIL %s accept_ready: got aw/w/ar=%b want %b", tag, {bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o}, {is_wr, is_wr, !is_wr}); end
        tick();
        if (is_wr) begin bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0; end
        else bus.ar_valid_i = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            checks++; if ({bus.reg_valid_o, bus.reg_write_o} !== {1'b1, is_wr}) begin errors++; $display("FAIL %s reg_valid_write[%0d]: got %b want %b", tag, i, {bus.reg_valid_o, bus.reg_write_o}, {1'b1, is_wr}); end
            checks++; if (bus.reg_addr_o !== addr) begin errors++; $display("FAIL %s reg_addr[%0d]: got %h want %h", tag, i, bus.reg_addr_o, addr); end
            checks++; if (bus.reg_wstrb_o !== (is_wr ? strb : 4'h0)) begin errors++; $display("FAIL %s reg_wstrb[%0d]: got %h want %h", tag, i, bus.reg_wstrb_o, is_wr ? strb : 4'h0); end
            if (is_wr) begin
                checks++; if (bus.reg_wdata_o !== data) begin errors++; $display("FAIL %s reg_wdata[%0d]: got %h want %h", tag, i, bus.reg_wdata_o, data); end
            end
            checks++; if ({bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o, bus.b_valid_o, bus.r_valid_o} !== 5'b0) begin errors++; $display("FAIL %s busy_quiet[%0d]: got %b want 00000", tag, i, {bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o, bus.b_valid_o, bus.r_valid_o}); end
            bus.reg_ready_i = (i == stall);
            bus.reg_error_i = (i == stall) ? err : 1'($urandom);
            bus.reg_rdata_i = (i == stall) ? rd : $urandom;
            tick();
        end
        bus.reg_ready_i = 1'b0;
        bus.reg_rdata_i = $urandom;
        bus.reg_error_i = 1'($urandom);
        if (is_wr && !err) begin
            merged = mem_rd(addr);
            for (int b = 0; b < 4; b++) if (strb[b]) merged[8*b +: 8] = data[8*b +: 8];
            mem[addr] = merged;
        end
        for (int i = 0; i <= rstall; i++) begin
            checks++; if ({bus.reg_valid_o, bus.b_valid_o, bus.r_valid_o} !== {1'b0, is_wr, !is_wr}) begin errors++; $display("FAIL %s resp_valid[%0d]: got reg/b/r=%b want %b", tag, i, {bus.reg_valid_o, bus.b_valid_o, bus.r_valid_o}, {1'b0, is_wr, !is_wr}); end
            if (is_wr) begin
                checks++; if (bus.b_resp_o !== exp_resp) begin errors++; $display("FAIL %s b_resp[%0d]: got %b want %b", tag, i, bus.b_resp_o, exp_resp); end
            end else begin
                checks++; if (bus.r_resp_o !== exp_resp) begin errors++; $display("FAIL %s r_resp[%0d]: got %b want %b", tag, i, bus.r_resp_o, exp_resp); end
                checks++; if (bus.r_data_o !== rd) begin errors++; $display("FAIL %s r_data[%0d]: got %h want %h", tag, i, bus.r_data_o, rd); end
            end
            if (is_wr) bus.b_ready_i = (i == rstall);
            else bus.r_ready_i = (i == rstall);
            tick();
        end
        bus.b_ready_i = 1'b0;
        bus.r_ready_i = 1'b0;
        checks++; if ({bus.b_valid_o, bus.r_valid_o} !== 2'b00) begin errors++; $display("FAIL %s resp_drop: got b/r=%b want 00", tag, {bus.b_valid_o, bus.r_valid_o}); end
        exp_prio_w = !is_wr;
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.aw_addr_i = a; bus.w_data_i = d; bus.w_strb_i = s;
        bus.aw_valid_i = 1'b1; bus.w_valid_i = 1'b1;
    endtask

    task automatic drive_read(input logic [31:0] a);
        bus.ar_addr_i = a; bus.ar_valid_i = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_write(32'h4, 32'h1, 4'hF);
        drive_read(32'h8);
        tick();
        tick();
        checks++; if ({bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o, bus.b_valid_o, bus.r_valid_o, bus.reg_valid_o, bus.reg_write_o} !== 7'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 0000000", {bus.aw_ready_o, bus.w_ready_o, bus.ar_ready_o, bus.b_valid_o, bus.r_valid_o, bus.reg_valid_o, bus.reg_write_o}); end
        checks++; if ({bus.reg_addr_o, bus.reg_wdata_o, bus.reg_wstrb_o, bus.r_data_o, bus.b_resp_o, bus.r_resp_o} !== '0) begin errors++; $display("FAIL reset_data: addr=%h wdata=%h wstrb=%h rdata=%h bresp=%b rresp=%b want all zero", bus.reg_addr_o, bus.reg_wdata_o, bus.reg_wstrb_o, bus.r_data_o, bus.b_resp_o, bus.r_resp_o); end
        bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0; bus.ar_valid_i = 1'b0;
        rst = 1'b0;
        exp_prio_w = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        drive_write(32'h10, 32'hDEADBEEF, 4'hF);
        run_txn("single_write", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0, 0);
    endtask

    task automatic test_read_stall();
        mem[32'h24] = 32'h12345678;
        drive_read(32'h24);
        run_txn("read_stall", 1'b0, 32'h24, 32'h0, 4'h0, 1'b0, 4, 0);
    endtask

    task automatic test_error();
        mem[32'h40] = 32'hAA;
        drive_read(32'h40);
        run_txn("err_read", 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 0, 1);
        drive_write(32'h44, 32'h5555AAAA, 4'h3);
        run_txn("err_write", 1'b1, 32'h44, 32'h5555AAAA, 4'h3, 1'b1, 1, 0);
    endtask

    task automatic test_back_to_back();
        bit seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] wa, wd, ra;
        rst = 1'b1; tick(); rst = 1'b0;
        exp_prio_w = 1'b1;
        wa = 32'h100; wd = $urandom; ra = 32'h104;
        drive_write(wa, wd, 4'hF);
        drive_read(ra);
        for (int i = 0; i < 4; i++) begin
            if (seq[i]) begin
                run_txn("b2b_write", 1'b1, wa, wd, 4'hF, 1'b0, 0, 0);
                wa = wa + 32'h8; wd = $urandom;
                drive_write(wa, wd, 4'hF);
            end else begin
                run_txn("b2b_read", 1'b0, ra, 32'h0, 4'h0, 1'b0, 0, 0);
                ra = ra + 32'h8;
                drive_read(ra);
            end
        end
        bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0; bus.ar_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_aw_without_w();
        bus.aw_addr_i = 32'h200; bus.aw_valid_i = 1'b1;
        bus.w_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({bus.aw_ready_o, bus.w_ready_o, bus.reg_valid_o} !== 3'b000) begin errors++; $display("FAIL aw_only[%0d]: got aw_ready/w_ready/reg_valid=%b want 000", i, {bus.aw_ready_o, bus.w_ready_o, bus.reg_valid_o}); end
            tick();
        end
        drive_write(32'h200, 32'hCAFEF00D, 4'h0);
        run_txn("aw_then_w", 1'b1, 32'h200, 32'hCAFEF00D, 4'h0, 1'b0, 0, 0);
    endtask

    task automatic test_backpressure_reset();
        drive_write(32'h80, 32'h0BADCAFE, 4'hF);
        run_txn("b_backpressure", 1'b1, 32'h80, 32'h0BADCAFE, 4'hF, 1'b1, 0, 3);
        drive_read(32'h84);
        tick();
        bus.ar_valid_i = 1'b0;
        bus.reg_ready_i = 1'b0;
        tick();
        checks++; if (bus.reg_valid_o !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got reg_valid=%b want 1", bus.reg_valid_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_prio_w = 1'b1;
        checks++; if ({bus.reg_valid_o, bus.reg_write_o, bus.b_valid_o, bus.r_valid_o, bus.aw_ready_o, bus.ar_ready_o} !== 6'b0) begin errors++; $display("FAIL rst_mid_req: got %b want 000000", {bus.reg_valid_o, bus.reg_write_o, bus.b_valid_o, bus.r_valid_o, bus.aw_ready_o, bus.ar_ready_o}); end
        bus.reg_ready_i = 1'b1;
        bus.r_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({bus.reg_valid_o, bus.b_valid_o, bus.r_valid_o} !== 3'b000) begin errors++; $display("FAIL rst_no_resp[%0d]: got %b want 000", i, {bus.reg_valid_o, bus.b_valid_o, bus.r_valid_o}); end
        end
        bus.reg_ready_i = 1'b0;
        bus.r_ready_i = 1'b0;
        drive_write(32'h88, 32'h11223344, 4'hF);
        run_txn("post_reset_write", 1'b1, 32'h88, 32'h11223344, 4'hF, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        bit          pend_w = 1'b0, pend_r = 1'b0, win_w;
        logic [31:0] wa, wd, ra;
        logic [3:0]  ws;
        for (int n = 0; n < 40; n++) begin
            if (!pend_w && ($urandom_range(0, 1) == 1)) begin
                wa = {26'h0, 4'($urandom_range(0, 7)), 2'b00}; wd = $urandom; ws = 4'($urandom);
                pend_w = 1'b1; drive_write(wa, wd, ws);
            end
            if (!pend_r && ($urandom_range(0, 1) == 1)) begin
                ra = {26'h0, 4'($urandom_range(0, 7)), 2'b00};
                pend_r = 1'b1; drive_read(ra);
            end
            if (!pend_w && !pend_r) begin
                wa = {26'h0, 4'($urandom_range(0, 7)), 2'b00}; wd = $urandom; ws = 4'($urandom);
                pend_w = 1'b1; drive_write(wa, wd, ws);
            end
            win_w = pend_w && (!pend_r || exp_prio_w);
            if (win_w) begin
                run_txn("rand_write", 1'b1, wa, wd, ws, $urandom_range(0, 7) == 0, $urandom_range(0, 2), $urandom_range(0, 2));
                pend_w = 1'b0;
            end else begin
                run_txn("rand_read", 1'b0, ra, 32'h0, 4'h0, $urandom_range(0, 7) == 0, $urandom_range(0, 2), $urandom_range(0, 2));
                pend_r = 1'b0;
            end
        end
        bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0; bus.ar_valid_i = 1'b0;
        tick();
    endtask

    initial begin
        bus.aw_addr_i = '0; bus.aw_valid_i = 1'b0;
        bus.w_data_i = '0; bus.w_strb_i = '0; bus.w_valid_i = 1'b0;
        bus.b_ready_i = 1'b0;
        bus.ar_addr_i = '0; bus.ar_valid_i = 1'b0;
        bus.r_ready_i = 1'b0;
        bus.reg_ready_i = 1'b0; bus.reg_rdata_i = '0; bus.reg_error_i = 1'b0;
        exp_prio_w = 1'b1;
        test_reset();
        test_single_write();
        test_read_stall();
        test_error();
        test_back_to_back();
        test_aw_without_w();
        test_backpressure_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_lite_reg_bridge.md
Name: axi_lite_reg_bridge

Overview:
AXI4-Lite slave endpoint that sits directly downstream of an AXI4-Lite register cut. It terminates the five AXI4-Lite channels and serializes reads and writes onto a single-outstanding, valid/ready register request bus for peripheral register files. Only one transaction is in flight at a time. Reads and writes are arbitrated round-robin.

Parameters:
ADDR_WIDTH, 32, address width of the AXI-Lite and register buses
DATA_WIDTH, 32, data width; must be 32 or 64
STRB_WIDTH, DATA_WIDTH/8, derived; do not override

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
aw_addr_i  in  ADDR_WIDTH  write address
aw_valid_i  in  1  write address valid
aw_ready_o  out  1  write address ready
w_data_i  in  DATA_WIDTH  write data
w_strb_i  in  STRB_WIDTH  write byte strobes
w_valid_i  in  1  write data valid
w_ready_o  out  1  write data ready
b_resp_o  out  2  write response
b_valid_o  out  1  write response valid
b_ready_i  in  1  write response ready
ar_addr_i  in  ADDR_WIDTH  read address
ar_valid_i  in  1  read address valid
ar_ready_o  out  1  read address ready
r_data_o  out  DATA_WIDTH  read data
r_resp_o  out  2  read response
r_valid_o  out  1  read response valid
r_ready_i  in  1  read response ready
reg_valid_o  out  1  register request valid
reg_ready_i  in  1  register request accepted/completed
reg_write_o  out  1  1 = write, 0 = read
reg_addr_o  out  ADDR_WIDTH  register address
reg_wdata_o  out  DATA_WIDTH  write data
reg_wstrb_o  out  STRB_WIDTH  write strobes; all-zero on reads
reg_rdata_i  in  DATA_WIDTH  read data, sampled when reg_valid_o & reg_ready_i
reg_error_i  in  1  error flag, sampled with reg_rdata_i

Behaviour:
- FSM states: IDLE, REQ, WRESP, RRESP. All outputs are driven from registers. There is no combinational path from any input to any output, except aw/w/ar_ready_o, which are decoded from state and input valids.
- Reset (rst_i=1 at a clock edge): state=IDLE, prio=WRITE, all valid/ready outputs 0, reg_write_o=0, all data/addr/resp outputs 0. Reset mid-transaction drops the transaction. No b/r response is issued for it.
- IDLE, write eligibility: aw_valid_i & w_valid_i are both high. AW and W are always accepted in the same cycle, never separately.
- IDLE, read eligibility: ar_valid_i is high.
- IDLE, grant rules:
  - Only one eligible: grant it.
  - Both eligible: grant the side indicated by prio, then flip prio to the other side.
  - A lone grant sets prio to the non-granted side.
- IDLE, on a write grant: aw_ready_o=w_ready_o=1 for that cycle. Latch addr, data and strb. reg_write_o=1. Go to REQ.
- IDLE, on a read grant: ar_ready_o=1. Latch addr. reg_wstrb_o=0. reg_write_o=0. Go to REQ.
- IDLE, when not granted: all ready outputs are 0.
- REQ:
  - reg_valid_o=1, starting the cycle after the AXI handshake.
  - reg_addr/wdata/wstrb/write stay stable until reg_ready_i.
  - On reg_valid_o & reg_ready_i: capture reg_rdata_i (reads) and reg_error_i; drop reg_valid_o; go to WRESP or RRESP.
  - No timeout: a stalled reg_ready_i holds the bridge in REQ indefinitely.
- WRESP:
  - b_valid_o=1. b_resp_o = 2'b10 (SLVERR) if the captured error is set, else 2'b00 (OKAY).
  - Held stable until b_ready_i. On the handshake, go to IDLE.
- RRESP:
  - r_valid_o=1. r_data_o = captured data. r_resp_o as for WRESP.
  - On r_ready_i, go to IDLE.
  - Captured data is returned even on error.
- Latency: AXI accept at cycle N → reg_valid_o at N+1. reg_ready_i at cycle M → b/r_valid_o at M+1. Response handshake at cycle K → IDLE at K+1, so a new accept is possible at K+1.
  - Minimum 3 cycles per transaction (reg_ready_i tied high, response ready high).
- Ready outputs are never asserted outside IDLE. The bridge never accepts a second address while one is outstanding.
- Write with w_strb_i=0: forwarded unchanged. The register side decides the effect.
- Address is passed through unmodified. No alignment or decode is performed.

Test Plan:
- Single write: AW addr 0x10, W data 0xDEADBEEF, strb 0xF, reg_ready_i tied 1, err 0 → aw/w ready at N; reg_valid_o, write=1, addr 0x10 at N+1; b_valid_o, resp 00 at N+2; IDLE after b_ready_i.
- Single read with stall: AR addr 0x24, reg_ready_i held low 4 cycles then high with rdata 0x12345678 → reg request stable for 5 cycles; r_data_o=0x12345678, r_resp_o=00 one cycle later.
- Error path: read of 0x40 with reg_error_i=1, rdata 0xAA → r_resp_o=2'b10, r_data_o=0xAA. Write with error → b_resp_o=2'b10.
- Simultaneous AW+W and AR valid for 4 back-to-back transactions → grant order W, R, W, R. Each AXI handshake occurs only in IDLE.
- AW valid without W for 5 cycles, then W arrives → no handshake until both are valid; both accepted in the same cycle.
- Backpressure and reset: b_ready_i low 3 cycles → b_valid_o/b_resp_o stable. Then assert rst_i while in REQ → next cycle all valids 0, state IDLE, no response emitted.
